// File: rtl/dmem_pkg.sv
// Shared constants for the data-side memory subsystem: control bus bit
// indices, status word bit positions and default memory-mapped addresses.
package dmem_pkg;

  localparam int CTRL_WR = 2;
  localparam int CTRL_RD = 1;
  localparam int CTRL_RW = 0;

  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL  = 17;
  localparam int STAT_OVF   = 18;

  localparam logic [63:0] DEF_CONSOLE_ADDR = 64'hFFFF_0000;
  localparam logic [63:0] DEF_STATUS_ADDR  = 64'hFFFF_0008;

  function automatic logic [63:0] status_word(input logic [15:0] count,
                                              input logic        empty,
                                              input logic        full,
                                              input logic        ovf);
    logic [63:0] w;
    w             = '0;
    w[15:0]       = count;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL]  = full;
    w[STAT_OVF]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/dmem_sync_fifo.sv
// Synchronous FIFO with a registered head output; a pop on a full FIFO
// frees the slot that a same-cycle push then takes.
module dmem_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; the empty gate on dout hides stale entries.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data memory + console FIFO behind the single-cycle CPU buses.
// Optional DMEM_RANGE_CHECK_EN adds a sticky addr_err for out-of-range RAM accesses.
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int          MEM_BYTES    = 4096,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [63:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [63:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] AddressBus,
  input  logic [63:0] DataBusOut,
  input  logic [2:0]  ControlBus,
  output logic [63:0] DataBusIn,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en, rd_en, unused_rw;
  logic          console_sel, status_sel, ram_sel, ram_ok;
  logic [AW-1:0] ram_idx;
  logic [63:0]   ram_rdata;
  logic [7:0]    mem_q [MEM_BYTES];

  logic          fifo_push, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow_q, overflow_d, ovf_set, ovf_clr;

  assign wr_en     = ControlBus[CTRL_WR];
  assign rd_en     = ControlBus[CTRL_RD];
  assign unused_rw = ControlBus[CTRL_RW];

  assign console_sel = (AddressBus == CONSOLE_ADDR);
  assign status_sel  = (AddressBus == STATUS_ADDR);
  assign ram_sel     = !console_sel && !status_sel;
  assign ram_idx     = AddressBus[AW-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  logic [64:0] end_addr;
  logic        range_bad, addr_err_q;

  assign end_addr  = {1'b0, AddressBus} + 65'd7;
  assign range_bad = (AddressBus >= 64'(MEM_BYTES)) || (end_addr >= 65'(MEM_BYTES));
  assign ram_ok    = ram_sel && !range_bad;
  assign addr_err  = addr_err_q;

  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else if ((rd_en || wr_en) && ram_sel && range_bad) addr_err_q <= 1'b1;
  end
`else
  assign ram_ok = ram_sel;
`endif

  // Eight little-endian bytes; the index arithmetic wraps at the top of RAM.
  always_ff @(posedge clk) begin
    if (wr_en && ram_ok && !rst) begin
      for (int i = 0; i < 8; i++) mem_q[ram_idx + AW'(i)] <= DataBusOut[8*i +: 8];
    end
  end

  always_comb begin
    ram_rdata = '0;
    for (int i = 0; i < 8; i++) ram_rdata[8*i +: 8] = mem_q[ram_idx + AW'(i)];
  end

  always_comb begin
    DataBusIn = '0;
    if (rd_en) begin
      if (status_sel)
        DataBusIn = status_word(16'(fifo_count), fifo_empty, fifo_full, overflow_q);
      else if (ram_ok)
        DataBusIn = ram_rdata;
    end
  end

  assign fifo_push = wr_en && console_sel && !rst;

  dmem_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (tx_ready),
    .din_i   (DataBusOut[7:0]),
    .dout_o  (tx_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_valid = !fifo_empty;

  // A full FIFO with a same-cycle pop accepts the push, so no overflow then.
  assign ovf_set = fifo_push && fifo_full && !tx_ready;
  assign ovf_clr = wr_en && status_sel && DataBusOut[STAT_OVF];

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set)      overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed self-checking bench for dmem_bus_ctrl (default build).
module tb_dmem_bus_ctrl;

  localparam logic [63:0] CON = 64'hFFFF_0000;
  localparam logic [63:0] STA = 64'hFFFF_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] AddressBus;
  logic [63:0] DataBusOut;
  logic [2:0]  ControlBus;
  logic [63:0] DataBusIn;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dmem_bus_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .AddressBus (AddressBus),
    .DataBusOut (DataBusOut),
    .ControlBus (ControlBus),
    .DataBusIn  (DataBusIn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .overflow   (overflow)
  );

  // Bus drivers: inputs change at the falling edge, commits happen at the rising edge.
  task automatic bus_write(input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    AddressBus = addr;
    DataBusOut = data;
    ControlBus = 3'b100;
    @(posedge clk);
    #1;
    ControlBus = 3'b000;
  endtask

  task automatic bus_read(input logic [63:0] addr, output logic [63:0] v);
    @(negedge clk);
    AddressBus = addr;
    ControlBus = 3'b010;
    #1;
    v = DataBusIn;
    ControlBus = 3'b000;
  endtask

  task automatic test_reset;
    logic [63:0] v;
    rst = 1'b1; tx_ready = 1'b0; ControlBus = '0; AddressBus = '0; DataBusOut = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (tx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    compared++;
    if (tx_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    bus_read(STA, v);
    compared++;
    if (v !== 64'h10000) begin mismatched++; $display("[TB] FAIL reset_status: got %h expected %h", v, 64'h10000); end
  endtask

  task automatic test_ram_basic;
    logic [63:0] v;
    bus_write(64'h18, 64'h0);
    bus_write(64'h10, 64'h1122334455667788);
    bus_read(64'h10, v);
    compared++;
    if (v !== 64'h1122334455667788) begin mismatched++; $display("[TB] FAIL ram_load_aligned: got %h expected %h", v, 64'h1122334455667788); end
    bus_read(64'h13, v);
    compared++;
    if (v !== 64'h0000001122334455) begin mismatched++; $display("[TB] FAIL ram_load_unaligned: got %h expected %h", v, 64'h0000001122334455); end
    @(negedge clk);
    AddressBus = 64'h10;
    ControlBus = 3'b000;
    #1;
    compared++;
    if (DataBusIn !== 64'h0) begin mismatched++; $display("[TB] FAIL ram_no_read_zero: got %h expected 0", DataBusIn); end
    DataBusOut = 64'hCAFEBABEDEADBEEF;
    ControlBus = 3'b110;
    #1;
    compared++;
    if (DataBusIn !== 64'h1122334455667788) begin mismatched++; $display("[TB] FAIL ram_read_old_on_write: got %h expected %h", DataBusIn, 64'h1122334455667788); end
    @(posedge clk);
    #1;
    ControlBus = 3'b000;
    bus_read(64'h10, v);
    compared++;
    if (v !== 64'hCAFEBABEDEADBEEF) begin mismatched++; $display("[TB] FAIL ram_after_rw: got %h expected %h", v, 64'hCAFEBABEDEADBEEF); end
    bus_read(CON, v);
    compared++;
    if (v !== 64'h0) begin mismatched++; $display("[TB] FAIL console_read_zero: got %h expected 0", v); end
  endtask

  task automatic test_ram_wrap;
    logic [63:0] v;
    bus_write(64'h4, 64'h0);
    bus_write(64'hFFC, 64'hAABBCCDDEEFF0011);
    bus_read(64'hFFC, v);
    compared++;
    if (v !== 64'hAABBCCDDEEFF0011) begin mismatched++; $display("[TB] FAIL wrap_load_ffc: got %h expected %h", v, 64'hAABBCCDDEEFF0011); end
    bus_read(64'h0, v);
    compared++;
    if (v !== 64'h00000000AABBCCDD) begin mismatched++; $display("[TB] FAIL wrap_low_bytes: got %h expected %h", v, 64'h00000000AABBCCDD); end
    bus_read(64'hFFE, v);
    compared++;
    if (v !== 64'h0000AABBCCDDEEFF) begin mismatched++; $display("[TB] FAIL wrap_load_ffe: got %h expected %h", v, 64'h0000AABBCCDDEEFF); end
  endtask

  task automatic test_console_drain;
    logic [63:0] v;
    logic [7:0]  exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    for (int i = 0; i < 3; i++) bus_write(CON, {56'h0, exp_b[i]});
    bus_read(STA, v);
    compared++;
    if (v !== 64'h3) begin mismatched++; $display("[TB] FAIL drain_status_before: got %h expected 3", v); end
    compared++;
    if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL drain_head: got %h/%b expected 41/1", tx_data, tx_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      compared++;
      if (tx_data !== exp_b[i]) begin mismatched++; $display("[TB] FAIL drain_byte%0d: got %h expected %h", i, tx_data, exp_b[i]); end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    tx_ready = 1'b0;
    compared++;
    if (tx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_empty_valid: got %b expected 0", tx_valid); end
    bus_read(STA, v);
    compared++;
    if (v !== 64'h10000) begin mismatched++; $display("[TB] FAIL drain_status_after: got %h expected %h", v, 64'h10000); end
  endtask

  task automatic test_overflow;
    logic [63:0] v;
    for (int i = 0; i < 17; i++) bus_write(CON, 64'(i));
    bus_read(STA, v);
    compared++;
    if (v !== 64'h60010) begin mismatched++; $display("[TB] FAIL ovf_status: got %h expected %h", v, 64'h60010); end
    compared++;
    if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_flag_set: got %b expected 1", overflow); end
    bus_write(STA, 64'h40000);
    bus_read(STA, v);
    compared++;
    if (v !== 64'h20010) begin mismatched++; $display("[TB] FAIL ovf_cleared_status: got %h expected %h", v, 64'h20010); end
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_flag_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_simultaneous;
    logic [63:0] v;
    logic [7:0]  exp;
    @(negedge clk);
    AddressBus = CON;
    DataBusOut = 64'h5A;
    ControlBus = 3'b100;
    tx_ready   = 1'b1;
    @(posedge clk);
    #1;
    ControlBus = 3'b000;
    tx_ready   = 1'b0;
    bus_read(STA, v);
    compared++;
    if (v !== 64'h20010) begin mismatched++; $display("[TB] FAIL simul_status: got %h expected %h", v, 64'h20010); end
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL simul_no_ovf: got %b expected 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'h5A : 8'(i + 1);
      @(negedge clk);
      tx_ready = 1'b1;
      compared++;
      if (tx_data !== exp || tx_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL simul_drain%0d: got %h/%b expected %h/1", i, tx_data, tx_valid, exp); end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    tx_ready = 1'b0;
    compared++;
    if (tx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL simul_empty: got %b expected 0", tx_valid); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] v;
    for (int i = 0; i < 5; i++) bus_write(CON, 64'(8'h61 + i));
    bus_read(STA, v);
    compared++;
    if (v !== 64'h5) begin mismatched++; $display("[TB] FAIL midrst_before: got %h expected 5", v); end
    @(negedge clk);
    rst        = 1'b1;
    AddressBus = 64'h10;
    DataBusOut = 64'h0;
    ControlBus = 3'b100;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst        = 1'b0;
    ControlBus = 3'b000;
    #1;
    compared++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin mismatched++; $display("[TB] FAIL midrst_tx: got %h/%b expected 00/0", tx_data, tx_valid); end
    bus_read(STA, v);
    compared++;
    if (v !== 64'h10000) begin mismatched++; $display("[TB] FAIL midrst_status: got %h expected %h", v, 64'h10000); end
    bus_read(64'h10, v);
    compared++;
    if (v !== 64'hCAFEBABEDEADBEEF) begin mismatched++; $display("[TB] FAIL midrst_ram_kept: got %h expected %h", v, 64'hCAFEBABEDEADBEEF); end
  endtask

  initial begin
    test_reset;
    test_ram_basic;
    test_ram_wrap;
    test_console_drain;
    test_overflow;
    test_simultaneous;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
